// File: rtl/ring_router_vc_pkg.sv
// router_pkg: shared types and flit field helpers for the ring router.
//
// Contents:
//   route_e     - routing decision for an upstream flit (forward or eject)
//   MAX_FLIT_W  - widest flit the field helpers accept
//   vc_width()  - VC index width, max(1, clog2(NUM_VC))
//   dest_of()   - extract the destination node id, flit[NODE_W-1:0]
//   vc_of()     - extract the raw VC field, flit[NODE_W+VC_W-1:NODE_W]
//                 (the caller folds it modulo NUM_VC)
package router_pkg;

    typedef enum logic {
        ROUTE_FORWARD = 1'b0,
        ROUTE_EJECT   = 1'b1
    } route_e;

    localparam int MAX_FLIT_W = 64;

    function automatic int vc_width(input int numVc);
        return (numVc <= 1) ? 1 : $clog2(numVc);
    endfunction

    function automatic int dest_of(input logic [MAX_FLIT_W-1:0] flit, input int nodeW);
        return int'(flit & ((64'(1) << nodeW) - 64'(1)));
    endfunction

    function automatic int vc_of(input logic [MAX_FLIT_W-1:0] flit, input int nodeW, input int vcW);
        return int'((flit >> nodeW) & ((64'(1) << vcW) - 64'(1)));
    endfunction

endpackage

// File: rtl/ring_router_vc_if.sv
// ring_router_vc_if: one valid/ready flit link.
//
// Signals:
//   data   - flit payload, FLIT_W bits
//   valid  - data is valid
//   ready  - receiver accepts the flit this cycle
// Modports:
//   master - drives data/valid, observes ready
//   slave  - observes data/valid, drives ready
interface ring_router_vc_if #(
    parameter int FLIT_W = 8
);
    logic [FLIT_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ring_router_vc_fifo.sv
// vc_fifo: one virtual-channel FIFO of the ring router.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   push/din - write din when not full
//   pop/dout - dout is the head entry (combinational); pop drops it when not empty
//   full     - registered occupancy == VC_DEPTH
//   empty    - registered occupancy == 0
// A simultaneous push and pop is allowed. The full flag only falls in the
// cycle after a pop, so a push is refused when full even if a pop happens.
module vc_fifo #(
    parameter int FLIT_W   = 8,
    parameter int VC_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] din,
    output logic [FLIT_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(VC_DEPTH);
    localparam int CNT_W = $clog2(VC_DEPTH + 1);

    logic [FLIT_W-1:0] r_mem [VC_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic              w_wrEn;
    logic              w_rdEn;

    assign full   = (r_count == CNT_W'(VC_DEPTH));
    assign empty  = (r_count == '0);
    assign dout   = r_mem[r_rdPtr];
    assign w_wrEn = push && !full;
    assign w_rdEn = pop && !empty;

    // Storage has no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    // Pointers wrap explicitly so VC_DEPTH need not be a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_wrEn) begin
                r_wrPtr <= (r_wrPtr == PTR_W'(VC_DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
            end
            if (w_rdEn) begin
                r_rdPtr <= (r_rdPtr == PTR_W'(VC_DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
            end
            case ({w_wrEn, w_rdEn})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/ring_router_vc.sv
// ring_router_vc: single-direction ring router with per-VC FIFOs.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   current_node - this node's id (quasi-static)
//   up           - slave link from the upstream router
//   ni_in        - slave link carrying flits injected by the local NI
//   down         - master link to the downstream router (registered)
//   ni_out       - master link carrying ejected flits to the NI (registered)
//   free         - registered: no flit buffered anywhere in the router
// Upstream flits addressed to current_node are ejected to ni_out; all other
// upstream flits and every NI flit are queued in FIFO[vc]. The down register
// is fed round-robin from the non-empty FIFOs.
module ring_router_vc
    import router_pkg::*;
#(
    parameter int FLIT_W   = 8,
    parameter int NODE_W   = 2,
    parameter int NUM_VC   = 2,
    parameter int VC_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] current_node,
    ring_router_vc_if.slave   up,
    ring_router_vc_if.slave   ni_in,
    ring_router_vc_if.master  down,
    ring_router_vc_if.master  ni_out,
    output logic              free
);
    localparam int VC_W  = vc_width(NUM_VC);
    localparam int TOT_W = $clog2(NUM_VC * VC_DEPTH + 3);

    logic [NODE_W-1:0] w_upDest;
    logic [VC_W-1:0]   w_upVc;
    logic [VC_W-1:0]   w_niVc;
    route_e            w_upRoute;
    logic              w_upFire;
    logic              w_upFwdFire;
    logic              w_upEjectFire;
    logic              w_niFire;

    logic [NUM_VC-1:0] w_push;
    logic [NUM_VC-1:0] w_pop;
    logic [NUM_VC-1:0] w_full;
    logic [NUM_VC-1:0] w_empty;
    logic [FLIT_W-1:0] w_fifoDin  [NUM_VC];
    logic [FLIT_W-1:0] w_fifoDout [NUM_VC];

    logic              w_anyReq;
    logic [VC_W-1:0]   w_winner;
    int                w_scanIdx;
    logic              w_downLoad;
    logic              w_niOutLoad;

    logic [VC_W-1:0]   r_rrPtr;
    logic              r_downValid;
    logic [FLIT_W-1:0] r_downData;
    logic              r_niOutValid;
    logic [FLIT_W-1:0] r_niOutData;
    logic [TOT_W-1:0]  r_total;
    logic [TOT_W-1:0]  w_totalNext;
    logic              r_free;

    // Field extraction; out-of-range VC values fold back modulo NUM_VC.
    assign w_upDest  = NODE_W'(dest_of(MAX_FLIT_W'(up.data), NODE_W));
    assign w_upVc    = VC_W'(vc_of(MAX_FLIT_W'(up.data), NODE_W, VC_W) % NUM_VC);
    assign w_niVc    = VC_W'(vc_of(MAX_FLIT_W'(ni_in.data), NODE_W, VC_W) % NUM_VC);
    assign w_upRoute = (w_upDest == current_node) ? ROUTE_EJECT : ROUTE_FORWARD;

    assign w_niOutLoad = !r_niOutValid || ni_out.ready;
    assign w_downLoad  = !r_downValid || down.ready;

    // Upstream through-traffic wins a FIFO over the NI in the same cycle.
    assign up.ready    = (w_upRoute == ROUTE_EJECT) ? w_niOutLoad : !w_full[w_upVc];
    assign ni_in.ready = !w_full[w_niVc] &&
                         !(up.valid && (w_upRoute == ROUTE_FORWARD) && (w_upVc == w_niVc));

    assign w_upFire      = up.valid && up.ready;
    assign w_upFwdFire   = w_upFire && (w_upRoute == ROUTE_FORWARD);
    assign w_upEjectFire = w_upFire && (w_upRoute == ROUTE_EJECT);
    assign w_niFire      = ni_in.valid && ni_in.ready;

    // At most one writer per FIFO; the ready logic already keeps the NI off
    // a FIFO the upstream flit is using.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            w_push[v]    = 1'b0;
            w_fifoDin[v] = up.data;
            if (w_upFwdFire && (w_upVc == VC_W'(v))) begin
                w_push[v] = 1'b1;
            end else if (w_niFire && (w_niVc == VC_W'(v))) begin
                w_push[v]    = 1'b1;
                w_fifoDin[v] = ni_in.data;
            end
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : gen_vc
        vc_fifo #(
            .FLIT_W   (FLIT_W),
            .VC_DEPTH (VC_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[g]),
            .pop   (w_pop[g]),
            .din   (w_fifoDin[g]),
            .dout  (w_fifoDout[g]),
            .full  (w_full[g]),
            .empty (w_empty[g])
        );
    end

    // Round-robin: first non-empty FIFO scanning cyclically from r_rrPtr.
    always_comb begin
        w_anyReq  = 1'b0;
        w_winner  = '0;
        w_scanIdx = 0;
        w_pop     = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            w_scanIdx = (int'(r_rrPtr) + i) % NUM_VC;
            if (!w_anyReq && !w_empty[w_scanIdx]) begin
                w_anyReq = 1'b1;
                w_winner = VC_W'(w_scanIdx);
            end
        end
        if (w_downLoad && w_anyReq) begin
            w_pop[w_winner] = 1'b1;
        end
    end

    // Down register and arbiter pointer; data holds once the valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_downValid <= 1'b0;
            r_downData  <= '0;
            r_rrPtr     <= '0;
        end else if (w_downLoad) begin
            r_downValid <= w_anyReq;
            if (w_anyReq) begin
                r_downData <= w_fifoDout[w_winner];
                r_rrPtr    <= (w_winner == VC_W'(NUM_VC - 1)) ? '0 : w_winner + VC_W'(1);
            end
        end
    end

    // Eject register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_niOutValid <= 1'b0;
            r_niOutData  <= '0;
        end else if (w_upEjectFire) begin
            r_niOutValid <= 1'b1;
            r_niOutData  <= up.data;
        end else if (ni_out.ready) begin
            r_niOutValid <= 1'b0;
        end
    end

    // Flits in flight (FIFOs plus both output registers): +1 per accepted
    // flit, -1 per completed output handshake. free is registered from the
    // next value, so it drops in the cycle after any acceptance.
    always_comb begin
        w_totalNext = r_total;
        if (w_upFire)                     w_totalNext = w_totalNext + TOT_W'(1);
        if (w_niFire)                     w_totalNext = w_totalNext + TOT_W'(1);
        if (r_downValid && down.ready)    w_totalNext = w_totalNext - TOT_W'(1);
        if (r_niOutValid && ni_out.ready) w_totalNext = w_totalNext - TOT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_total <= '0;
            r_free  <= 1'b1;
        end else begin
            r_total <= w_totalNext;
            r_free  <= (w_totalNext == '0);
        end
    end

    assign down.data    = r_downData;
    assign down.valid   = r_downValid;
    assign ni_out.data  = r_niOutData;
    assign ni_out.valid = r_niOutValid;
    assign free         = r_free;
endmodule
